// File: rtl/duty_table_access_ctrl_pkg.sv
// Shared types and constants for the duty table access controller.
// Holds the queued write record, the window state encoding and the threshold reset value.
package duty_table_access_ctrl_pkg;

  localparam logic [15:0] FULL_WIDTH_START_INIT = 16'd65025;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_req_t;

  localparam int WR_REQ_W = $bits(wr_req_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } duty_access_state_t;

endpackage

// File: rtl/duty_table_access_ctrl_sync_fifo.sv
// Small synchronous FIFO with an active-low synchronous reset and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rdPtr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/duty_table_access_ctrl.sv
// Arbitrates the duty table BRAM between encoder burst reads and queued CPU writes.
// Writes and threshold changes only take effect outside a read window.
module duty_table_access_ctrl #(
  parameter int          DEPTH                 = 249,
  parameter int          GUARD                 = 4,
  parameter int          WR_FIFO_DEPTH         = 4,
  parameter logic [15:0] FULL_WIDTH_START_INIT = duty_table_access_ctrl_pkg::FULL_WIDTH_START_INIT
) (
  input  logic                             CLK,
  input  logic                             RESETN,
  input  logic                             DIN_VALID,
  input  logic [15:0]                      RD_IDX,
  output logic [7:0]                       RD_VALUE,
  input  logic                             WR_VALID,
  output logic                             WR_READY,
  input  logic [15:0]                      WR_ADDR,
  input  logic [7:0]                       WR_DATA,
  input  logic [15:0]                      FWS_IN,
  input  logic                             FWS_UPDATE,
  output logic [15:0]                      FWS_OUT,
  output logic [15:0]                      BRAM_ADDR,
  output logic                             BRAM_WE,
  output logic [7:0]                       BRAM_DIN,
  input  logic [7:0]                       BRAM_DOUT,
  output logic                             BUSY,
  output logic [$clog2(WR_FIFO_DEPTH):0]   PENDING
);

  import duty_table_access_ctrl_pkg::*;

  localparam int            WIN      = DEPTH + GUARD;
  localparam int            CW       = $clog2(WIN);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIN - 1);

  duty_access_state_t r_state;
  duty_access_state_t w_nextState;
  logic [CW-1:0]      r_winCnt;
  logic [15:0]        r_fwsPend;
  logic               r_fwsPendFlag;
  logic               w_readSel;
  logic               w_fwsSlot;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  wr_req_t            w_pushReq;
  wr_req_t            w_head;
  logic [WR_REQ_W-1:0] w_headBits;

  assign w_pushReq = '{addr: WR_ADDR, data: WR_DATA};
  assign w_head    = wr_req_t'(w_headBits);
  assign WR_READY  = !w_full;
  assign BRAM_DIN  = w_head.data;
  assign RD_VALUE  = BRAM_DOUT;

  sync_fifo #(
    .WIDTH (WR_REQ_W),
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wrFifo (
    .i_clk    (CLK),
    .i_resetn (RESETN),
    .i_push   (WR_VALID),
    .i_data   (w_pushReq),
    .i_pop    (w_pop),
    .o_data   (w_headBits),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (PENDING)
  );

  always_ff @(posedge CLK) begin
    if (!RESETN) r_state <= ST_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (DIN_VALID)             w_nextState = ST_READ;
      ST_READ: if (r_winCnt == LAST_CNT)  w_nextState = ST_IDLE;
      default:                            w_nextState = ST_IDLE;
    endcase
  end

  // Counter sits at zero outside a window so a new burst always starts from 0.
  always_ff @(posedge CLK) begin
    if (!RESETN)                                           r_winCnt <= '0;
    else if (r_state == ST_READ && w_nextState == ST_READ) r_winCnt <= r_winCnt + 1'b1;
    else                                                   r_winCnt <= '0;
  end

  always_comb begin
    w_readSel = (r_state == ST_READ) || DIN_VALID;
    BUSY      = (r_state == ST_READ);
    BRAM_ADDR = RD_IDX;
    BRAM_WE   = 1'b0;
    w_pop     = 1'b0;
    if (!w_readSel && !w_empty) begin
      BRAM_ADDR = w_head.addr;
      BRAM_WE   = 1'b1;
      w_pop     = 1'b1;
    end
  end

  // A strobe arriving while an older value is being applied stays pending for a later slot.
  assign w_fwsSlot = (r_state == ST_IDLE) && !DIN_VALID;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      FWS_OUT       <= FULL_WIDTH_START_INIT;
      r_fwsPend     <= FULL_WIDTH_START_INIT;
      r_fwsPendFlag <= 1'b0;
    end else if (w_fwsSlot && r_fwsPendFlag) begin
      FWS_OUT       <= r_fwsPend;
      r_fwsPendFlag <= FWS_UPDATE;
      if (FWS_UPDATE) r_fwsPend <= FWS_IN;
    end else if (w_fwsSlot && FWS_UPDATE) begin
      FWS_OUT <= FWS_IN;
    end else if (FWS_UPDATE) begin
      r_fwsPend     <= FWS_IN;
      r_fwsPendFlag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_duty_table_access_ctrl.sv
// Self-checking bench for duty_table_access_ctrl: constant vector table, directed window
// sequences and a randomized run compared against a cycle-indexed behavioural model.
module tb_duty_table_access_ctrl;

  localparam int          DEPTH    = 249;
  localparam int          GUARD    = 4;
  localparam int          WIN      = DEPTH + GUARD;
  localparam logic [15:0] FWS_INIT = 16'd65025;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        DIN_VALID;
  logic [15:0] RD_IDX;
  logic [7:0]  RD_VALUE;
  logic        WR_VALID;
  logic        WR_READY;
  logic [15:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic [15:0] FWS_IN;
  logic        FWS_UPDATE;
  logic [15:0] FWS_OUT;
  logic [15:0] BRAM_ADDR;
  logic        BRAM_WE;
  logic [7:0]  BRAM_DIN;
  logic [7:0]  BRAM_DOUT;
  logic        BUSY;
  logic [2:0]  PENDING;

  duty_table_access_ctrl dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .DIN_VALID  (DIN_VALID),
    .RD_IDX     (RD_IDX),
    .RD_VALUE   (RD_VALUE),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .FWS_IN     (FWS_IN),
    .FWS_UPDATE (FWS_UPDATE),
    .FWS_OUT    (FWS_OUT),
    .BRAM_ADDR  (BRAM_ADDR),
    .BRAM_WE    (BRAM_WE),
    .BRAM_DIN   (BRAM_DIN),
    .BRAM_DOUT  (BRAM_DOUT),
    .BUSY       (BUSY),
    .PENDING    (PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        resetn;
    logic        din;
    logic        wrValid;
    logic [15:0] wrAddr;
    logic [7:0]  wrData;
    logic        fwsUpd;
    logic [15:0] fwsIn;
    logic [15:0] rdIdx;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        expWe;
    logic [15:0] expAddr;
    logic [7:0]  expDin;
    logic [2:0]  expPending;
    logic        expBusy;
    logic        expReady;
    logic [15:0] expFws;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } mreq_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model: queue of writes, window start cycle, threshold registers.
  mreq_t       mQ[$];
  bit          modelValid = 1'b0;
  bit          mHasWin    = 1'b0;
  int          mStart     = 0;
  logic [15:0] mFws       = FWS_INIT;
  logic [15:0] mPend      = FWS_INIT;
  bit          mPendFlag  = 1'b0;

  logic        obsWe, obsBusy, obsReady;
  logic [15:0] obsAddr, obsFws;
  logic [7:0]  obsDin, tbDout;
  logic [2:0]  obsPending;

  function automatic stim_t mkStim(input logic din, input logic wrValid, input logic [15:0] wrAddr,
                                   input logic [7:0] wrData, input logic fwsUpd,
                                   input logic [15:0] fwsIn, input logic [15:0] rdIdx);
    stim_t s;
    s.resetn  = 1'b1;
    s.din     = din;
    s.wrValid = wrValid;
    s.wrAddr  = wrAddr;
    s.wrData  = wrData;
    s.fwsUpd  = fwsUpd;
    s.fwsIn   = fwsIn;
    s.rdIdx   = rdIdx;
    return s;
  endfunction

  function automatic stim_t idleS(input logic [15:0] rd);
    return mkStim(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, rd);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    RESETN     = s.resetn;
    DIN_VALID  = s.din;
    WR_VALID   = s.wrValid;
    WR_ADDR    = s.wrAddr;
    WR_DATA    = s.wrData;
    FWS_UPDATE = s.fwsUpd;
    FWS_IN     = s.fwsIn;
    RD_IDX     = s.rdIdx;
    BRAM_DOUT  = 8'($urandom);
    tbDout     = BRAM_DOUT;
  endtask

  task automatic stepCycle(input stim_t s);
    logic        expBusy, expWe, expReady, applyNow;
    logic [15:0] expAddr;
    int          qs;
    @(negedge CLK);
    applyStimulus(s);
    #1;
    obsWe      = BRAM_WE;
    obsAddr    = BRAM_ADDR;
    obsDin     = BRAM_DIN;
    obsBusy    = BUSY;
    obsReady   = WR_READY;
    obsPending = PENDING;
    obsFws     = FWS_OUT;
    qs       = mQ.size();
    expBusy  = mHasWin && (cyc > mStart) && (cyc <= mStart + WIN);
    expWe    = !(expBusy || s.din) && (qs > 0);
    expAddr  = expWe ? mQ[0].addr : s.rdIdx;
    expReady = (qs < 4);
    if (modelValid) begin
      checkOutput("busy",    32'(obsBusy),    32'(expBusy));
      checkOutput("we",      32'(obsWe),      32'(expWe));
      checkOutput("addr",    32'(obsAddr),    32'(expAddr));
      if (expWe) checkOutput("bramDin", 32'(obsDin), 32'(mQ[0].data));
      checkOutput("ready",   32'(obsReady),   32'(expReady));
      checkOutput("pending", 32'(obsPending), 32'(qs));
      checkOutput("fws",     32'(obsFws),     32'(mFws));
      checkOutput("rdValue", 32'(RD_VALUE),   32'(tbDout));
    end
    if (!s.resetn) begin
      mQ.delete();
      mFws       = FWS_INIT;
      mPendFlag  = 1'b0;
      mHasWin    = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      applyNow = !expBusy && !s.din;
      if (expWe) void'(mQ.pop_front());
      if (s.wrValid && expReady) mQ.push_back('{s.wrAddr, s.wrData});
      if (s.din && !expBusy) begin
        mHasWin = 1'b1;
        mStart  = cyc;
      end
      if (applyNow && !mPendFlag && s.fwsUpd) begin
        mFws = s.fwsIn;
      end else begin
        if (applyNow && mPendFlag) begin
          mFws      = mPend;
          mPendFlag = 1'b0;
        end
        if (s.fwsUpd) begin
          mPend     = s.fwsIn;
          mPendFlag = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  task automatic doReset();
    stim_t s;
    s = idleS(16'h0);
    s.resetn = 1'b0;
    stepCycle(s);
    stepCycle(s);
  endtask

  vec_t tbl[7];

  initial begin
    stim_t s;
    int    t, t2, weCnt, lowCnt, lowAt, devCnt, c;

    applyStimulus(idleS(16'h0));
    RESETN = 1'b0;

    tbl[0] = '{mkStim(1'b0, 1'b1, 16'h0010, 8'h11, 1'b0, 16'h0,    16'h00A0), 1'b0, 16'h00A0, 8'h00, 3'd0, 1'b0, 1'b1, FWS_INIT};
    tbl[1] = '{mkStim(1'b0, 1'b1, 16'h0020, 8'h22, 1'b0, 16'h0,    16'h00A1), 1'b1, 16'h0010, 8'h11, 3'd1, 1'b0, 1'b1, FWS_INIT};
    tbl[2] = '{mkStim(1'b0, 1'b1, 16'h0030, 8'h33, 1'b0, 16'h0,    16'h00A2), 1'b1, 16'h0020, 8'h22, 3'd1, 1'b0, 1'b1, FWS_INIT};
    tbl[3] = '{mkStim(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'hABCD, 16'h00A3), 1'b1, 16'h0030, 8'h33, 3'd1, 1'b0, 1'b1, FWS_INIT};
    tbl[4] = '{mkStim(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0,    16'h00A4), 1'b0, 16'h00A4, 8'h00, 3'd0, 1'b0, 1'b1, 16'hABCD};
    tbl[5] = '{mkStim(1'b1, 1'b1, 16'h0040, 8'h44, 1'b0, 16'h0,    16'h00B5), 1'b0, 16'h00B5, 8'h00, 3'd0, 1'b0, 1'b1, 16'hABCD};
    tbl[6] = '{mkStim(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0,    16'h00B6), 1'b0, 16'h00B6, 8'h00, 3'd1, 1'b1, 1'b1, 16'hABCD};

    // Reset values
    doReset();
    stepCycle(idleS(16'h0042));
    checkOutput("rstBusy",    32'(obsBusy),    32'(0));
    checkOutput("rstWe",      32'(obsWe),      32'(0));
    checkOutput("rstPending", 32'(obsPending), 32'(0));
    checkOutput("rstReady",   32'(obsReady),   32'(1));
    checkOutput("rstFws",     32'(obsFws),     32'(FWS_INIT));

    // Constant vector table: three writes drain one per cycle, strobe applies next cycle
    for (int i = 0; i < 7; i++) begin
      stepCycle(tbl[i].s);
      checkOutput("tblWe",      32'(obsWe),      32'(tbl[i].expWe));
      checkOutput("tblAddr",    32'(obsAddr),    32'(tbl[i].expAddr));
      if (tbl[i].expWe) checkOutput("tblDin", 32'(obsDin), 32'(tbl[i].expDin));
      checkOutput("tblPending", 32'(obsPending), 32'(tbl[i].expPending));
      checkOutput("tblBusy",    32'(obsBusy),    32'(tbl[i].expBusy));
      checkOutput("tblReady",   32'(obsReady),   32'(tbl[i].expReady));
      checkOutput("tblFws",     32'(obsFws),     32'(tbl[i].expFws));
    end

    // Full queue meets a back-to-back burst
    doReset();
    t = cyc;
    stepCycle(mkStim(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 16'h0001));
    for (int k = 0; k < 4; k++)
      stepCycle(mkStim(1'b0, 1'b1, 16'(16'h0100 * (k + 1)), 8'(8'hA0 + k), 1'b0, 16'h0, 16'h0002));
    stepCycle(idleS(16'h0003));
    checkOutput("fullNotReady", 32'(obsReady), 32'(0));
    weCnt = 0;
    while (cyc < t + WIN + 1) begin
      stepCycle(idleS(16'(cyc)));
      weCnt += int'(obsWe);
    end
    stepCycle(mkStim(1'b1, 1'b1, 16'hBEEF, 8'hEE, 1'b0, 16'h0, 16'h0004));
    checkOutput("readyAtDin", 32'(obsReady), 32'(0));
    checkOutput("weAtDin",    32'(obsWe),    32'(0));
    t2 = t + WIN + 1;
    while (cyc <= t2 + WIN) begin
      stepCycle(idleS(16'(cyc)));
      weCnt += int'(obsWe);
    end
    checkOutput("noWeInWindows", 32'(weCnt), 32'(0));
    for (int k = 0; k < 4; k++) begin
      stepCycle(idleS(16'h0005));
      checkOutput("drainWe",    32'(obsWe),    32'(1));
      checkOutput("drainAddr",  32'(obsAddr),  32'(16'h0100 * (k + 1)));
      checkOutput("drainReady", 32'(obsReady), (k == 0) ? 32'(0) : 32'(1));
    end
    stepCycle(idleS(16'h0006));
    checkOutput("drainEmpty", 32'(obsPending), 32'(0));

    // Pending write collides with burst start in IDLE
    doReset();
    stepCycle(mkStim(1'b0, 1'b1, 16'h0555, 8'h55, 1'b0, 16'h0, 16'h0000));
    t = cyc;
    stepCycle(mkStim(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 16'h0077));
    checkOutput("collideWe",   32'(obsWe),   32'(0));
    checkOutput("collideAddr", 32'(obsAddr), 32'(16'h0077));
    weCnt = 0;
    while (cyc < t + WIN + 1) begin
      stepCycle(idleS(16'(cyc)));
      weCnt += int'(obsWe);
    end
    checkOutput("collideNoWe", 32'(weCnt), 32'(0));
    stepCycle(idleS(16'h0078));
    checkOutput("lateWe",   32'(obsWe),   32'(1));
    checkOutput("lateAddr", 32'(obsAddr), 32'(16'h0555));
    checkOutput("lateData", 32'(obsDin),  32'(8'h55));

    // Two threshold strobes within one window: only the last one lands, after the window
    doReset();
    t = cyc;
    stepCycle(mkStim(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 16'h0010));
    devCnt = 0;
    while (cyc < t + WIN + 2) begin
      s = idleS(16'(cyc));
      if (cyc == t + 50)  begin s.fwsUpd = 1'b1; s.fwsIn = 16'h1234; end
      if (cyc == t + 100) begin s.fwsUpd = 1'b1; s.fwsIn = 16'h5678; end
      stepCycle(s);
      if (obsFws !== FWS_INIT) devCnt++;
    end
    checkOutput("fwsHeld", 32'(devCnt), 32'(0));
    stepCycle(idleS(16'h0011));
    checkOutput("fwsApplied", 32'(obsFws), 32'(16'h5678));

    // Back-to-back bursts leave a single idle cycle and no write
    doReset();
    t = cyc;
    stepCycle(mkStim(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 16'h0020));
    stepCycle(mkStim(1'b0, 1'b1, 16'h0999, 8'h99, 1'b0, 16'h0, 16'h0021));
    lowCnt = 0;
    lowAt  = -1;
    weCnt  = 0;
    while (cyc < t + 2 * (WIN + 1)) begin
      c = cyc;
      s = idleS(16'(cyc));
      if (c == t + WIN + 1) s.din = 1'b1;
      stepCycle(s);
      if (!obsBusy) begin
        lowCnt++;
        lowAt = c;
      end
      weCnt += int'(obsWe);
    end
    checkOutput("b2bLowCount", 32'(lowCnt), 32'(1));
    checkOutput("b2bLowAt",    32'(lowAt - t), 32'(WIN + 1));
    checkOutput("b2bNoWe",     32'(weCnt), 32'(0));
    stepCycle(idleS(16'h0022));
    checkOutput("b2bWe",   32'(obsWe),   32'(1));
    checkOutput("b2bAddr", 32'(obsAddr), 32'(16'h0999));

    // Reset in the middle of a window drops writes and any pending threshold
    doReset();
    t = cyc;
    stepCycle(mkStim(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 16'h0030));
    stepCycle(mkStim(1'b0, 1'b1, 16'h0A0A, 8'hAA, 1'b0, 16'h0, 16'h0031));
    stepCycle(mkStim(1'b0, 1'b1, 16'h0B0B, 8'hBB, 1'b1, 16'h4321, 16'h0032));
    while (cyc < t + 100) stepCycle(idleS(16'(cyc)));
    s = idleS(16'h0033);
    s.resetn = 1'b0;
    stepCycle(s);
    stepCycle(idleS(16'h0034));
    checkOutput("midRstBusy",    32'(obsBusy),    32'(0));
    checkOutput("midRstPending", 32'(obsPending), 32'(0));
    checkOutput("midRstFws",     32'(obsFws),     32'(FWS_INIT));
    checkOutput("midRstReady",   32'(obsReady),   32'(1));
    checkOutput("midRstWe",      32'(obsWe),      32'(0));
    stepCycle(idleS(16'h0035));
    checkOutput("midRstFwsKept", 32'(obsFws),     32'(FWS_INIT));

    // Randomized traffic against the model
    doReset();
    for (int i = 0; i < 4000; i++) begin
      s.resetn  = ($urandom_range(0, 999) != 0);
      s.din     = ($urandom_range(0, 199) == 0);
      s.wrValid = 1'($urandom_range(0, 1));
      s.wrAddr  = 16'($urandom);
      s.wrData  = 8'($urandom);
      s.fwsUpd  = ($urandom_range(0, 24) == 0);
      s.fwsIn   = 16'($urandom);
      s.rdIdx   = 16'($urandom);
      stepCycle(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
